// File: rtl/rr_arbiter_32.sv
// 32-way round-robin arbiter with descending-priority search, per-grant hold limit
// and a one-cycle timeout pulse when a grant is forcibly released.
module rr_arbiter_32 #(
    parameter int unsigned MAX_HOLD = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] req,
    input  logic        done,
    output logic [31:0] gnt,
    output logic [4:0]  gnt_id,
    output logic        gnt_valid,
    output logic        timeout
);

    localparam int unsigned N     = 32;
    localparam int unsigned ID_W  = 5;
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] hold_q, hold_d;

    logic             pick_found_c;
    logic [ID_W-1:0]  pick_id_c;
    logic             early_release_c;
    logic             hold_hit_c;

    // First set request walking down from ptr, wrapping 0 -> 31.
    always_comb begin
        pick_found_c = 1'b0;
        pick_id_c    = '0;
        for (int i = 0; i < N; i++) begin
            if (!pick_found_c && req[ptr_q - ID_W'(i)]) begin
                pick_found_c = 1'b1;
                pick_id_c    = ptr_q - ID_W'(i);
            end
        end
    end

    // Done or a dropped request outranks the hold limit.
    assign early_release_c = done | ~req[gnt_id_q];
    assign hold_hit_c      = (hold_q == HOLD_LIMIT);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        hold_d      = hold_q;

        unique case (state_q)
            IDLE: begin
                gnt_d       = '0;
                gnt_id_d    = '0;
                gnt_valid_d = 1'b0;
                hold_d      = '0;
                if (pick_found_c) begin
                    state_d            = GRANT;
                    gnt_d[pick_id_c]   = 1'b1;
                    gnt_id_d           = pick_id_c;
                    gnt_valid_d        = 1'b1;
                    hold_d             = CNT_W'(1);
                    ptr_d              = pick_id_c - ID_W'(1);
                end
            end
            GRANT: begin
                if (early_release_c || hold_hit_c) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                    hold_d      = '0;
                    timeout_d   = hold_hit_c & ~early_release_c;
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= ID_W'(N - 1);
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            hold_q      <= hold_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_32.sv
// Scoreboard bench for rr_arbiter_32: driver steps a behavioural model and queues
// the expected outputs; an independent monitor compares them after each rising edge.
module tb_rr_arbiter_32;

    localparam int unsigned HOLD = 4;

    logic        clk;
    logic        rst;
    logic [31:0] req;
    logic        done;
    logic [31:0] gnt;
    logic [4:0]  gnt_id;
    logic        gnt_valid;
    logic        timeout;

    rr_arbiter_32 #(.MAX_HOLD(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    typedef struct {
        logic [31:0] gnt;
        logic [4:0]  id;
        logic        valid;
        logic        to;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Model: owner = -1 when nobody holds the resource.
    int m_owner;
    int m_ptr;
    int m_hold;
    bit m_to;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, want, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 31;
        m_hold  = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic [31:0] r, input logic d);
        exp_t e;
        if (m_owner < 0) begin
            m_to = 1'b0;
            for (int i = 0; i < 32; i++) begin
                int idx;
                idx = (m_ptr - i + 32) % 32;
                if (m_owner < 0 && r[idx]) begin
                    m_owner = idx;
                    m_hold  = 1;
                    m_ptr   = (idx + 31) % 32;
                end
            end
        end else begin
            bit quit;
            bit limit;
            quit  = d || !r[m_owner];
            limit = (m_hold == HOLD);
            if (quit || limit) begin
                m_to    = !quit && limit;
                m_owner = -1;
                m_hold  = 0;
            end else begin
                m_to   = 1'b0;
                m_hold = m_hold + 1;
            end
        end
        e.gnt   = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        e.id    = (m_owner >= 0) ? 5'(m_owner) : 5'd0;
        e.valid = (m_owner >= 0);
        e.to    = m_to;
        exp_q.push_back(e);
    endtask

    // Inputs for the coming rising edge, set on the falling edge.
    task automatic cyc(input logic [31:0] r, input logic d);
        @(negedge clk);
        req  = r;
        done = d;
        model_step(r, d);
    endtask

    // Monitor: one queued expectation per edge following a driven cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("gnt", gnt, e.gnt);
                check("gnt_id", 32'(gnt_id), 32'(e.id));
                check("gnt_valid", 32'(gnt_valid), 32'(e.valid));
                check("timeout", 32'(timeout), 32'(e.to));
            end
        end
    end

    initial begin
        logic [31:0] rr;
        logic        dd;
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        model_reset();
        #2;
        check("reset_gnt", gnt, 32'd0);
        check("reset_valid", 32'(gnt_valid), 32'd0);
        check("reset_timeout", 32'(timeout), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset priority, then bit 0 after ptr moved to 30.
        cyc(32'h8000_0001, 1'b0);
        cyc(32'h8000_0001, 1'b1);
        cyc(32'h8000_0001, 1'b0);
        cyc(32'h8000_0001, 1'b1);

        // Full rotation with done in every grant cycle.
        for (int i = 0; i < 33; i++) begin
            cyc(32'hFFFF_FFFF, 1'b0);
            cyc(32'hFFFF_FFFF, 1'b1);
        end
        cyc(32'h0, 1'b0);

        // Wrap-around: grant 0, then 1 from ptr=31, then 0.
        cyc(32'h1, 1'b0);
        cyc(32'h1, 1'b1);
        cyc(32'h3, 1'b0);
        cyc(32'h3, 1'b1);
        cyc(32'h3, 1'b0);
        cyc(32'h3, 1'b1);

        // Hold limit reached with no done: timeout then re-grant.
        for (int i = 0; i < 12; i++) cyc(32'h10, 1'b0);
        cyc(32'h0, 1'b0);
        cyc(32'h0, 1'b0);

        // Done coincident with the limit, then a requester dropping mid-grant.
        cyc(32'h20, 1'b0);
        cyc(32'h20, 1'b0);
        cyc(32'h20, 1'b0);
        cyc(32'h20, 1'b0);
        cyc(32'h20, 1'b1);
        cyc(32'h0, 1'b0);
        cyc(32'h40, 1'b0);
        cyc(32'h40, 1'b0);
        cyc(32'h0, 1'b0);
        cyc(32'h0, 1'b0);

        // Done while idle is ignored.
        cyc(32'h0, 1'b1);
        cyc(32'h0, 1'b1);

        // Random traffic; requests persist to let holds run to the limit.
        rr = '0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(3) == 0) rr = $urandom & $urandom;
            dd = ($urandom_range(5) == 0);
            cyc(rr, dd);
        end

        // Asynchronous reset in the middle of a grant.
        cyc(32'h0, 1'b0);
        cyc(32'h0, 1'b0);
        cyc(32'h0000_0400, 1'b0);
        cyc(32'h0000_0400, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        req = '0;
        done = 1'b0;
        #1;
        check("async_gnt", gnt, 32'd0);
        check("async_id", 32'(gnt_id), 32'd0);
        check("async_valid", 32'(gnt_valid), 32'd0);
        check("async_timeout", 32'(timeout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cyc(32'h0000_0100, 1'b0);
        cyc(32'h0000_0100, 1'b1);
        cyc(32'h0, 1'b0);

        @(negedge clk);
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
